// File: rtl/rgb_cmd_ctrl_if.sv
// Byte-stream command input and RGB duty/status outputs of the frame sequencer.
// The master drives bytes; the slave (sequencer) drives duties and status.
interface rgb_cmd_ctrl_if;
  logic [7:0] cmd_byte;
  logic       cmd_valid;
  logic [7:0] red_duty;
  logic [7:0] green_duty;
  logic [7:0] blue_duty;
  logic       upd_pulse;
  logic       err_pulse;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output cmd_byte, cmd_valid,
    input  red_duty, green_duty, blue_duty, upd_pulse, err_pulse, err_code, busy
  );

  modport slave (
    input  cmd_byte, cmd_valid,
    output red_duty, green_duty, blue_duty, upd_pulse, err_pulse, err_code, busy
  );
endinterface

// File: rtl/rgb_cmd_ctrl.sv
// Parses {SYNC, ADDR, DATA, CHK} frames from a UART byte stream and loads the
// addressed RGB duty register(s) on each valid frame; rejects bad frames with a code.
module rgb_cmd_ctrl #(
  parameter int         CLK_HZ      = 100_000_000,
  parameter int         TIMEOUT_CYC = CLK_HZ / 1000,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter logic [7:0] RST_DUTY    = 8'h00
) (
  input logic          clk,
  input logic          rst_n,
  rgb_cmd_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CHK
  } state_t;

  localparam logic [31:0] CNT_LAST = TIMEOUT_CYC - 1;

  localparam logic [1:0] ERR_ADDR    = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  red_q, red_d;
  logic [7:0]  green_q, green_d;
  logic [7:0]  blue_q, blue_d;
  logic        upd_q, upd_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        timeout;

  // An arriving byte always beats an expiring timer in the same cycle.
  assign timeout = (state_q != ST_IDLE) && !bus.cmd_valid && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    upd_d      = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    if (state_q == ST_IDLE || bus.cmd_valid || timeout) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    if (timeout) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else if (bus.cmd_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.cmd_byte == SYNC_BYTE) begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          addr_d = bus.cmd_byte;
          if (bus.cmd_byte <= 8'h03) begin
            state_d = ST_DATA;
          end else begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_ADDR;
          end
        end
        ST_DATA: begin
          data_d  = bus.cmd_byte;
          state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (bus.cmd_byte == (addr_q ^ data_q)) begin
            upd_d = 1'b1;
            unique case (addr_q[1:0])
              2'd0: red_d   = data_q;
              2'd1: green_d = data_q;
              2'd2: blue_d  = data_q;
              2'd3: begin
                red_d   = data_q;
                green_d = data_q;
                blue_d  = data_q;
              end
            endcase
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      red_q      <= RST_DUTY;
      green_q    <= RST_DUTY;
      blue_q     <= RST_DUTY;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.red_duty   = red_q;
  assign bus.green_duty = green_q;
  assign bus.blue_duty  = blue_q;
  assign bus.upd_pulse  = upd_q;
  assign bus.err_pulse  = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rgb_cmd_ctrl.sv
// Bench for rgb_cmd_ctrl: directed vector table, hand-written timeout sequences,
// and randomized byte streams compared against a frame-level reference model.
module tb_rgb_cmd_ctrl;

  localparam int         TO   = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       upd;
    logic       err;
    logic [1:0] code;
    logic       busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  rgb_cmd_ctrl_if bus();

  rgb_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Frame-level reference: bytes collected so far plus silent cycles since the last byte.
  logic [7:0] m_frame[$];
  int         m_idle;
  logic [7:0] m_red, m_green, m_blue;
  logic       m_upd, m_err, m_busy;
  logic [1:0] m_code;

  task automatic modelStep(input logic r, input logic v, input logic [7:0] b);
    m_upd = 1'b0;
    m_err = 1'b0;
    if (!r) begin
      m_frame.delete();
      m_idle  = 0;
      m_red   = 8'h00;
      m_green = 8'h00;
      m_blue  = 8'h00;
      m_code  = 2'b00;
    end else if (m_frame.size() == 0) begin
      if (v && b == SYNC) begin
        m_frame.push_back(b);
        m_idle = 0;
      end
    end else if (v) begin
      m_frame.push_back(b);
      m_idle = 0;
      if (m_frame.size() == 2 && b > 8'h03) begin
        m_err = 1'b1;
        m_code = 2'b01;
        m_frame.delete();
      end else if (m_frame.size() == 4) begin
        if (b == (m_frame[1] ^ m_frame[2])) begin
          m_upd = 1'b1;
          if (m_frame[1] == 8'h00 || m_frame[1] == 8'h03) m_red   = m_frame[2];
          if (m_frame[1] == 8'h01 || m_frame[1] == 8'h03) m_green = m_frame[2];
          if (m_frame[1] == 8'h02 || m_frame[1] == 8'h03) m_blue  = m_frame[2];
        end else begin
          m_err  = 1'b1;
          m_code = 2'b10;
        end
        m_frame.delete();
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_err  = 1'b1;
        m_code = 2'b11;
        m_idle = 0;
        m_frame.delete();
      end
    end
    m_busy = (m_frame.size() != 0);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] b);
    rst_n         = r;
    bus.cmd_valid = v;
    bus.cmd_byte  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%02h expected=%02h", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input logic upd, input logic err,
                             input logic [1:0] code, input logic busy);
    checkField(tag, "red",   bus.red_duty,   r);
    checkField(tag, "green", bus.green_duty, g);
    checkField(tag, "blue",  bus.blue_duty,  b);
    checkField(tag, "upd",   {7'd0, bus.upd_pulse}, {7'd0, upd});
    checkField(tag, "err",   {7'd0, bus.err_pulse}, {7'd0, err});
    checkField(tag, "code",  {6'd0, bus.err_code},  {6'd0, code});
    checkField(tag, "busy",  {7'd0, bus.busy},      {7'd0, busy});
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic [7:0] red, input logic [7:0] grn,
                              input logic [7:0] blu, input logic upd, input logic err,
                              input logic [1:0] code, input logic busy);
    vec_t t;
    t.rst_n = r;   t.valid = v;   t.data = d;
    t.red   = red; t.green = grn; t.blue = blu;
    t.upd   = upd; t.err   = err; t.code = code; t.busy = busy;
    return t;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [7:0] b;
    logic       v;
    int         sel;
    int         gap;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_byte  = 8'h00;

    //                rst v  byte   red    green  blue  upd err code busy
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 2'd0, 0));
    // good red frame
    vecs.push_back(mk(1, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 2'd0, 1));
    vecs.push_back(mk(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 2'd0, 1));
    vecs.push_back(mk(1, 1, 8'h80, 8'h00, 8'h00, 8'h00, 0, 0, 2'd0, 1));
    vecs.push_back(mk(1, 1, 8'h80, 8'h80, 8'h00, 8'h00, 1, 0, 2'd0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 8'h80, 8'h00, 8'h00, 0, 0, 2'd0, 0));
    // broadcast frame
    vecs.push_back(mk(1, 1, 8'hA5, 8'h80, 8'h00, 8'h00, 0, 0, 2'd0, 1));
    vecs.push_back(mk(1, 1, 8'h03, 8'h80, 8'h00, 8'h00, 0, 0, 2'd0, 1));
    vecs.push_back(mk(1, 1, 8'h3C, 8'h80, 8'h00, 8'h00, 0, 0, 2'd0, 1));
    vecs.push_back(mk(1, 1, 8'h3F, 8'h3C, 8'h3C, 8'h3C, 1, 0, 2'd0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd0, 0));
    // bad checksum on green
    vecs.push_back(mk(1, 1, 8'hA5, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd0, 1));
    vecs.push_back(mk(1, 1, 8'h01, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd0, 1));
    vecs.push_back(mk(1, 1, 8'h55, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd0, 1));
    vecs.push_back(mk(1, 1, 8'h00, 8'h3C, 8'h3C, 8'h3C, 0, 1, 2'd2, 0));
    vecs.push_back(mk(1, 0, 8'h00, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd2, 0));
    // bad address, then stray bytes ignored in idle
    vecs.push_back(mk(1, 1, 8'hA5, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd2, 1));
    vecs.push_back(mk(1, 1, 8'h07, 8'h3C, 8'h3C, 8'h3C, 0, 1, 2'd1, 0));
    vecs.push_back(mk(1, 1, 8'h12, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd1, 0));
    vecs.push_back(mk(1, 1, 8'h34, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd1, 0));
    // reset mid-frame; the trailing checksum byte is then ignored
    vecs.push_back(mk(1, 1, 8'hA5, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd1, 1));
    vecs.push_back(mk(1, 1, 8'h00, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd1, 1));
    vecs.push_back(mk(1, 1, 8'hFF, 8'h3C, 8'h3C, 8'h3C, 0, 0, 2'd1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 2'd0, 0));
    vecs.push_back(mk(1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 2'd0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 2'd0, 0));
    // sync value in the address slot is a bad address, not a resync
    vecs.push_back(mk(1, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 2'd0, 1));
    vecs.push_back(mk(1, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 1, 2'd1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 2'd1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].red, vecs[i].green, vecs[i].blue,
                  vecs[i].upd, vecs[i].err, vecs[i].code, vecs[i].busy);
    end

    // Silence in DATA for the full timeout window.
    applyStimulus(1, 1, 8'hA5);
    applyStimulus(1, 1, 8'h02);
    for (int k = 1; k < TO; k++) begin
      applyStimulus(1, 0, 8'h00);
      checkOutput($sformatf("to_wait%0d", k), 8'h00, 8'h00, 8'h00, 0, 0, 2'd1, 1);
    end
    applyStimulus(1, 0, 8'h00);
    checkOutput("to_expire", 8'h00, 8'h00, 8'h00, 0, 1, 2'd3, 0);
    applyStimulus(1, 0, 8'h00);
    checkOutput("to_after", 8'h00, 8'h00, 8'h00, 0, 0, 2'd3, 0);

    // A byte landing on the expiry cycle wins over the timeout.
    applyStimulus(1, 1, 8'hA5);
    applyStimulus(1, 1, 8'h02);
    for (int k = 1; k < TO; k++) applyStimulus(1, 0, 8'h00);
    applyStimulus(1, 1, 8'h11);
    checkOutput("to_race", 8'h00, 8'h00, 8'h00, 0, 0, 2'd3, 1);
    applyStimulus(1, 1, 8'h13);
    checkOutput("to_race_chk", 8'h00, 8'h00, 8'h11, 1, 0, 2'd3, 0);

    // Randomized streams against the reference model.
    modelStep(0, 0, 8'h00);
    applyStimulus(0, 0, 8'h00);
    checkOutput("rnd_reset", m_red, m_green, m_blue, m_upd, m_err, m_code, m_busy);
    for (int i = 0; i < 4000; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 1) begin
        modelStep(0, 0, 8'h00);
        applyStimulus(0, 0, 8'h00);
        checkOutput("rnd_rst", m_red, m_green, m_blue, m_upd, m_err, m_code, m_busy);
      end else if (sel < 4) begin
        gap = $urandom_range(TO - 2, TO + 1);
        for (int k = 0; k < gap; k++) begin
          modelStep(1, 0, 8'h00);
          applyStimulus(1, 0, 8'h00);
          checkOutput("rnd_gap", m_red, m_green, m_blue, m_upd, m_err, m_code, m_busy);
        end
      end else begin
        v = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 9);
        if (sel < 3) b = SYNC;
        else if (sel < 6) b = 8'($urandom_range(0, 4));
        else if (sel < 8 && m_frame.size() == 3) b = m_frame[1] ^ m_frame[2];
        else b = 8'($urandom_range(0, 255));
        modelStep(1, v, b);
        applyStimulus(1, v, b);
        checkOutput("rnd", m_red, m_green, m_blue, m_upd, m_err, m_code, m_busy);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
